// File: rtl/core_pkg.sv
// Shared types, constants and decode helpers for the multi-cycle RV32I core.
// Also holds the instruction ROM contents and the combinational ALU/immediate logic.
package core_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4
    } state_e;

    // br_op[4:3] kind; br_op[2:0] carries funct3 for conditional branches
    localparam logic [1:0] BR_KIND_NONE   = 2'b00;
    localparam logic [1:0] BR_KIND_UNCOND = 2'b01;
    localparam logic [1:0] BR_KIND_COND   = 2'b10;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MDR = 2'd1,
        WB_PC4 = 2'd2,
        WB_IMM = 2'd3
    } wb_src_e;

    typedef struct packed {
        alu_op_e    alu_op;
        logic       alu_a_pc;
        logic       alu_b_imm;
        logic       ru_write;
        wb_src_e    wb_src;
        logic       dm_write;
        logic       is_load;
        logic       is_system;
        logic [4:0] br_op;
    } ctrl_t;

    function automatic alu_op_e alu_sel(input logic [2:0] funct3, input logic f7b5,
                                        input logic is_reg);
        alu_op_e op;
        case (funct3)
            3'b000:  op = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    function automatic ctrl_t decode_ctrl(input logic [31:0] instr);
        ctrl_t c;
        c = '0;
        case (instr[6:0])
            OP_IMM: begin
                c.alu_op    = alu_sel(instr[14:12], instr[30], 1'b0);
                c.alu_b_imm = 1'b1;
                c.ru_write  = 1'b1;
            end
            OP_REG: begin
                c.alu_op   = alu_sel(instr[14:12], instr[30], 1'b1);
                c.ru_write = 1'b1;
            end
            OP_LUI: begin
                c.ru_write = 1'b1;
                c.wb_src   = WB_IMM;
            end
            OP_AUIPC: begin
                c.alu_a_pc  = 1'b1;
                c.alu_b_imm = 1'b1;
                c.ru_write  = 1'b1;
            end
            OP_JAL: begin
                c.ru_write = 1'b1;
                c.wb_src   = WB_PC4;
                c.br_op    = {BR_KIND_UNCOND, 3'b000};
            end
            OP_JALR: begin
                c.alu_b_imm = 1'b1;
                c.ru_write  = 1'b1;
                c.wb_src    = WB_PC4;
            end
            OP_BRANCH: c.br_op = {BR_KIND_COND, instr[14:12]};
            OP_LOAD: begin
                c.alu_b_imm = 1'b1;
                c.is_load   = 1'b1;
                c.ru_write  = 1'b1;
                c.wb_src    = WB_MDR;
            end
            OP_STORE: begin
                c.alu_b_imm = 1'b1;
                c.dm_write  = 1'b1;
            end
            OP_SYSTEM: c.is_system = 1'b1;
            default:   c.ru_write  = 1'b0;
        endcase
        return c;
    endfunction

    function automatic logic [31:0] imm_gen(input logic [31:0] i);
        logic [31:0] imm;
        case (i[6:0])
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: imm = {{20{i[31]}}, i[31:20]};
            OP_STORE:         imm = {{20{i[31]}}, i[31:25], i[11:7]};
            OP_BRANCH:        imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            OP_JAL:           imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            OP_LUI, OP_AUIPC: imm = {i[31:12], 12'h000};
            default:          imm = 32'h0000_0000;
        endcase
        return imm;
    endfunction

    function automatic logic [31:0] alu_calc(input alu_op_e op, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] r;
        case (op)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_SLL:  r = a << b[4:0];
            ALU_SLT:  r = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: r = {31'd0, a < b};
            ALU_XOR:  r = a ^ b;
            ALU_SRL:  r = a >> b[4:0];
            ALU_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:   r = a | b;
            ALU_AND:  r = a & b;
            default:  r = a + b;
        endcase
        return r;
    endfunction

    // Board program: branches, jumps, load/store and an EBREAK halt.
    function automatic logic [31:0] imem_rom(input logic [4:0] idx);
        logic [31:0] w;
        case (idx)
            5'd0:    w = 32'h0050_0093; // addi x1,x0,5
            5'd1:    w = 32'h0010_8133; // add  x2,x1,x1
            5'd2:    w = 32'h0000_0463; // beq  x0,x0,+8
            5'd3:    w = 32'h0010_0493; // addi x9,x0,1
            5'd4:    w = 32'h0000_1463; // bne  x0,x0,+8
            5'd5:    w = 32'h00C0_01EF; // jal  x3,+12
            5'd6:    w = 32'h0020_0493; // addi x9,x0,2
            5'd7:    w = 32'h0030_0493; // addi x9,x0,3
            5'd8:    w = 32'h02D0_0213; // addi x4,x0,45
            5'd9:    w = 32'h0042_0067; // jalr x0,4(x4)
            5'd10:   w = 32'h0040_0493; // addi x9,x0,4
            5'd11:   w = 32'h0050_0493; // addi x9,x0,5
            5'd12:   w = 32'h0010_2023; // sw   x1,0(x0)
            5'd13:   w = 32'h0000_2283; // lw   x5,0(x0)
            5'd14:   w = 32'h0010_0073; // ebreak
            5'd15:   w = 32'h0020_2023; // sw   x2,0(x0)
            5'd16:   w = 32'h0000_2303; // lw   x6,0(x0)
            5'd17:   w = 32'h0000_006F; // jal  x0,0
            default: w = 32'h0000_0013; // nop
        endcase
        return w;
    endfunction

endpackage

// File: rtl/multicycle_core_branch_unit.sv
// Branch decision: compares A and B by funct3 for conditional branches,
// always taken for unconditional jumps, never taken otherwise.
module branch_unit
    import core_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [4:0]  br_op_i,
    output logic        taken_o
);

    // Resolve the taken flag from the branch kind and comparison
    always_comb begin
        taken_o = 1'b0;
        if (br_op_i[4]) begin
            case (br_op_i[2:0])
                3'b000:  taken_o = (a_i == b_i);
                3'b001:  taken_o = (a_i != b_i);
                3'b100:  taken_o = ($signed(a_i) < $signed(b_i));
                3'b101:  taken_o = ($signed(a_i) >= $signed(b_i));
                3'b110:  taken_o = (a_i < b_i);
                3'b111:  taken_o = (a_i >= b_i);
                default: taken_o = 1'b0;
            endcase
        end else if (br_op_i[4:3] == BR_KIND_UNCOND) begin
            taken_o = 1'b1;
        end else begin
            taken_o = 1'b0;
        end
    end

endmodule

// File: rtl/multicycle_core.sv
// Five-state multi-cycle RV32I core with run/step control, breakpoints,
// EBREAK/ECALL halt and a retired-instruction counter.
module multicycle_core
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32,
    parameter int          NUM_BP   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run_mode,
    input  logic                 step,
    input  logic [NUM_BP-1:0]    bp_en,
    input  logic [NUM_BP*32-1:0] bp_addr,
    output logic                 halted,
    output logic                 retire,
    output logic [31:0]          pc_out,
    output logic [31:0]          instr_out,
    output logic [31:0]          wb_data_out,
    output logic [2:0]           state_out,
    output logic [CNT_W-1:0]     instr_count
);

    state_e           state_q;
    logic [31:0]      pc_q;
    logic [31:0]      ir_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [31:0]      imm_q;
    logic [31:0]      alu_q;
    logic             taken_q;
    logic [31:0]      mdr_q;
    logic [31:0]      wb_data_q;
    logic [CNT_W-1:0] count_q;
    logic             halted_q;
    logic             retire_q;
    logic             step_q;
    logic [31:0]      regs_q [32];
    logic [31:0]      dmem_q [16];

    ctrl_t       ctrl_s;
    logic        step_edge_s;
    logic        advance_s;
    logic        taken_s;
    logic [31:0] alu_a_s;
    logic [31:0] alu_b_s;
    logic [31:0] alu_res_s;
    logic [31:0] pc_plus4_s;
    logic [31:0] next_pc_s;
    logic [31:0] wb_val_s;
    logic        ru_write_s;
    logic        dm_write_s;
    logic        bp_hit_s;

    assign ctrl_s      = decode_ctrl(ir_q);
    assign step_edge_s = step & ~step_q;
    // A halted core behaves like step mode until a step edge releases it
    assign advance_s   = (run_mode & ~halted_q) | step_edge_s;
    assign alu_a_s     = ctrl_s.alu_a_pc ? pc_q : a_q;
    assign alu_b_s     = ctrl_s.alu_b_imm ? imm_q : b_q;
    assign alu_res_s   = alu_calc(ctrl_s.alu_op, alu_a_s, alu_b_s);
    assign pc_plus4_s  = pc_q + 32'd4;
    assign ru_write_s  = (state_q == ST_WRITEBACK) && ctrl_s.ru_write && !reset;
    assign dm_write_s  = (state_q == ST_MEMORY) && ctrl_s.dm_write && !reset;

    branch_unit u_branch_unit (
        .a_i     (a_q),
        .b_i     (b_q),
        .br_op_i (ctrl_s.br_op),
        .taken_o (taken_s)
    );

    // Next-PC selection applied at the end of WRITEBACK
    always_comb begin
        next_pc_s = pc_plus4_s;
        if (ir_q[6:0] == OP_JALR) begin
            next_pc_s = (a_q + imm_q) & 32'hFFFF_FFFE;
        end else if (taken_q) begin
            next_pc_s = pc_q + imm_q;
        end else begin
            next_pc_s = pc_plus4_s;
        end
    end

    // Write-back source mux
    always_comb begin
        wb_val_s = alu_q;
        case (ctrl_s.wb_src)
            WB_ALU:  wb_val_s = alu_q;
            WB_MDR:  wb_val_s = mdr_q;
            WB_PC4:  wb_val_s = pc_plus4_s;
            WB_IMM:  wb_val_s = imm_q;
            default: wb_val_s = alu_q;
        endcase
    end

    // Breakpoint match against the PC the core is about to fetch
    always_comb begin
        bp_hit_s = 1'b0;
        for (int i = 0; i < NUM_BP; i++) begin
            if (bp_en[i] && (bp_addr[32*i +: 32] == next_pc_s)) begin
                bp_hit_s = 1'b1;
            end else begin
                bp_hit_s = bp_hit_s;
            end
        end
    end

    // Main FSM: sequencing, architectural state and debug outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= 32'h0000_0000;
            a_q       <= 32'h0000_0000;
            b_q       <= 32'h0000_0000;
            imm_q     <= 32'h0000_0000;
            alu_q     <= 32'h0000_0000;
            taken_q   <= 1'b0;
            mdr_q     <= 32'h0000_0000;
            wb_data_q <= 32'h0000_0000;
            count_q   <= '0;
            halted_q  <= 1'b0;
            retire_q  <= 1'b0;
            step_q    <= 1'b0;
        end else begin
            step_q   <= step;
            retire_q <= 1'b0;
            case (state_q)
                ST_FETCH: begin
                    ir_q <= imem_rom(pc_q[6:2]);
                    if (advance_s) begin
                        state_q  <= ST_DECODE;
                        halted_q <= 1'b0;
                    end else begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_DECODE: begin
                    a_q     <= regs_q[ir_q[19:15]];
                    b_q     <= regs_q[ir_q[24:20]];
                    imm_q   <= imm_gen(ir_q);
                    state_q <= ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    alu_q   <= alu_res_s;
                    taken_q <= taken_s;
                    state_q <= ST_MEMORY;
                end
                ST_MEMORY: begin
                    if (ctrl_s.is_load) begin
                        mdr_q <= dmem_q[alu_q[5:2]];
                    end
                    retire_q <= 1'b1;
                    state_q  <= ST_WRITEBACK;
                end
                ST_WRITEBACK: begin
                    pc_q      <= next_pc_s;
                    wb_data_q <= wb_val_s;
                    count_q   <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    halted_q  <= ctrl_s.is_system | bp_hit_s;
                    state_q   <= ST_FETCH;
                end
                default: state_q <= ST_FETCH;
            endcase
        end
    end

    // Register file; x0 is never written
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < 32; r++) begin
                regs_q[r] <= 32'h0000_0000;
            end
        end else if (ru_write_s && (ir_q[11:7] != 5'd0)) begin
            regs_q[ir_q[11:7]] <= wb_val_s;
        end
    end

    // Data memory word write at the edge ending MEMORY
    always_ff @(posedge clk) begin
        if (dm_write_s) begin
            dmem_q[alu_q[5:2]] <= b_q;
        end
    end

    assign halted      = halted_q;
    assign retire      = retire_q;
    assign pc_out      = pc_q;
    assign instr_out   = ir_q;
    assign wb_data_out = wb_data_q;
    assign state_out   = state_q;
    assign instr_count = count_q;

endmodule
